// File: rtl/digit_uart_tx.sv
// digit_uart_tx: buffers decimal digits from a binary-to-decimal converter and
// sends them as ASCII over an 8N1 UART line. The first digit of a run is followed
// by '.', and each run ends with CR LF once conv_done has been seen.
module digit_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit,
  input  logic       digit_valid,
  input  logic       conv_done,
  output logic       tx,
  output logic       busy,
  output logic       all_sent,
  output logic       overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CLK_W = $clog2(CLKS_PER_BIT);

  // Run progress: no character yet, first digit sent, separator sent
  localparam logic [1:0] RUN_NONE = 2'd0;
  localparam logic [1:0] RUN_ONE  = 2'd1;
  localparam logic [1:0] RUN_DOT  = 2'd2;

  // Terminator progress: nothing sent, CR sent, LF sent
  localparam logic [1:0] TERM_NONE = 2'd0;
  localparam logic [1:0] TERM_CR   = 2'd1;
  localparam logic [1:0] TERM_LF   = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t state, state_next;

  logic [3:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             empty, full, push, pop, drop;

  logic [CLK_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             bit_end, start_end;

  logic [1:0]       run_state, run_next;
  logic [1:0]       term_idx, term_next;
  logic [7:0]       load_char;
  logic             done, has_work, finish;

  function automatic logic [7:0] map_char(input logic [3:0] d);
    logic [7:0] c;
    if (d <= 4'd9) c = 8'h30 + {4'd0, d};
    else           c = 8'h3F;
    return c;
  endfunction

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(FIFO_DEPTH));
  // A digit arriving while a terminator is pending belongs to no run: drop it
  assign push  = digit_valid && !done && !full;
  assign drop  = digit_valid && (done || full);
  // The separator occupies a frame without consuming a buffered digit
  assign pop   = (state == S_LOAD) && !empty && (run_state != RUN_ONE);

  // The LOAD cycle is the first cycle of the start bit, so START runs one short
  assign bit_end   = (clk_cnt == CLK_W'(CLKS_PER_BIT - 1));
  assign start_end = (clk_cnt == CLK_W'(CLKS_PER_BIT - 2));

  assign has_work = !empty || (done && (term_idx != TERM_LF));
  assign finish   = (state == S_STOP) && bit_end && (term_idx == TERM_LF);

  // Digit buffer storage; contents are meaningless while the count is zero
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= digit;
  end

  // Buffer pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Choose the character for the frame being loaded
  always_comb begin
    load_char = 8'h0D;
    run_next  = run_state;
    term_next = term_idx;
    if (!empty) begin
      if (run_state == RUN_ONE) begin
        load_char = 8'h2E;
        run_next  = RUN_DOT;
      end else begin
        load_char = map_char(mem[rd_ptr]);
        if (run_state == RUN_NONE) run_next = RUN_ONE;
      end
    end else if (term_idx == TERM_NONE) begin
      load_char = 8'h0D;
      term_next = TERM_CR;
    end else begin
      load_char = 8'h0A;
      term_next = TERM_LF;
    end
  end

  // Character being shifted out
  always_ff @(posedge clk) begin
    if (state == S_LOAD) shreg <= load_char;
  end

  // Run, terminator and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_state <= RUN_NONE;
      term_idx  <= TERM_NONE;
      done      <= 1'b0;
      all_sent  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      all_sent <= finish;
      if (drop) overflow <= 1'b1;
      if (finish) begin
        done      <= 1'b0;
        run_state <= RUN_NONE;
        term_idx  <= TERM_NONE;
      end else begin
        if (conv_done) done <= 1'b1;
        if (state == S_LOAD) begin
          run_state <= run_next;
          term_idx  <= term_next;
        end
      end
    end
  end

  // Bit timing: cycle counter within a bit and data bit index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_cnt <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          clk_cnt <= '0;
          bit_idx <= '0;
        end
        S_START: clk_cnt <= start_end ? '0 : clk_cnt + CLK_W'(1);
        S_DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            bit_idx <= bit_idx + 3'd1;
          end else begin
            clk_cnt <= clk_cnt + CLK_W'(1);
          end
        end
        S_STOP:  clk_cnt <= bit_end ? '0 : clk_cnt + CLK_W'(1);
        default: clk_cnt <= '0;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (has_work) state_next = S_LOAD;
      S_LOAD:  state_next = S_START;
      S_START: if (start_end) state_next = S_DATA;
      S_DATA:  if (bit_end && (bit_idx == 3'd7)) state_next = S_STOP;
      S_STOP:  if (bit_end) state_next = (has_work && !finish) ? S_LOAD : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM outputs: line level and activity flag
  always_comb begin
    tx = 1'b1;
    case (state)
      S_LOAD:  tx = 1'b0;
      S_START: tx = 1'b0;
      S_DATA:  tx = shreg[bit_idx];
      default: tx = 1'b1;
    endcase
    busy = !empty || (state != S_IDLE) || done;
  end

endmodule

// File: tb/tb_digit_uart_tx.sv
// tb_digit_uart_tx: table-driven check of digit_uart_tx with a UART line decoder,
// plus hand-written sequences for latency, multi-run and mid-frame reset.
module tb_digit_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] digit = '0;
  logic       digit_valid = 1'b0;
  logic       conv_done = 1'b0;
  logic       tx, busy, all_sent, overflow;

  digit_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .digit(digit), .digit_valid(digit_valid),
    .conv_done(conv_done), .tx(tx), .busy(busy), .all_sent(all_sent),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int frame_err = 0;
  int as_cnt = 0;
  int busy_err = 0;
  logic [7:0] rx_q [$];
  logic [7:0] exp_q [$];
  logic [7:0] rx_byte;

  // Line decoder: samples each bit in its middle (cycle 2 of 4)
  always begin
    @(negedge clk);
    if (tx === 1'b0) begin
      repeat (2) @(negedge clk);
      if (tx !== 1'b0) frame_err++;
      for (int k = 0; k < 8; k++) begin
        repeat (4) @(negedge clk);
        rx_byte[k] = tx;
      end
      repeat (4) @(negedge clk);
      if (tx !== 1'b1) frame_err++;
      rx_q.push_back(rx_byte);
    end
  end

  // all_sent pulse counter; busy must already be low when it pulses
  always @(negedge clk) begin
    if (all_sent === 1'b1) begin
      as_cnt++;
      if (busy !== 1'b0) busy_err++;
    end
  end

  typedef struct {
    logic [23:0] digs;
    int          n_dig;
    int          done_mode;
    bit          late;
    int          n_exp;
    logic [63:0] exp_b;
    logic        exp_ovf;
    int          exp_as;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    digit_valid = 1'b0;
    conv_done   = 1'b0;
    digit       = '0;
    rst         = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_all_sent", all_sent, 0);
    chk("rst_overflow", overflow, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rx_q.delete();
    frame_err = 0;
    as_cnt    = 0;
    busy_err  = 0;
  endtask

  task automatic send(input logic [23:0] digs, input int n, input int dm, input bit late);
    for (int i = 0; i < n; i++) begin
      digit       = digs[4*i +: 4];
      digit_valid = 1'b1;
      conv_done   = (dm == 2) && (i == n - 1);
      tick();
    end
    digit_valid = 1'b0;
    conv_done   = 1'b0;
    if (dm == 1) begin
      conv_done = 1'b1;
      tick();
      conv_done = 1'b0;
    end
    if (late) begin
      digit       = 4'd4;
      digit_valid = 1'b1;
      conv_done   = 1'b1;
      tick();
      digit_valid = 1'b0;
      conv_done   = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_idle"}, busy, 0);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic cmp_bytes(input string name);
    logic [63:0] act;
    chk({name, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      act = (i < rx_q.size()) ? {56'd0, rx_q[i]} : 64'hFFFF;
      chk($sformatf("%s_b%0d", name, i), act, {56'd0, exp_q[i]});
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] c, input int i);
    logic b;
    if (i < 4)       b = 1'b0;
    else if (i < 36) b = c[(i - 4) / 4];
    else             b = 1'b1;
    return b;
  endfunction

  initial begin
    int low_cnt;
    string nm;

    vecs[0] = '{digs: 24'h008172, n_dig: 4, done_mode: 1, late: 0, n_exp: 7,
                exp_b: 64'h000A_0D38_3137_2E32, exp_ovf: 0, exp_as: 1};
    vecs[1] = '{digs: 24'h00000C, n_dig: 1, done_mode: 1, late: 0, n_exp: 3,
                exp_b: 64'h0A0D3F, exp_ovf: 0, exp_as: 1};
    vecs[2] = '{digs: 24'h000000, n_dig: 0, done_mode: 1, late: 0, n_exp: 2,
                exp_b: 64'h0A0D, exp_ovf: 0, exp_as: 1};
    vecs[3] = '{digs: 24'h000090, n_dig: 2, done_mode: 1, late: 0, n_exp: 5,
                exp_b: 64'h0A_0D39_2E30, exp_ovf: 0, exp_as: 1};
    vecs[4] = '{digs: 24'h000A3F, n_dig: 3, done_mode: 1, late: 0, n_exp: 6,
                exp_b: 64'h0A0D_3F33_2E3F, exp_ovf: 0, exp_as: 1};
    vecs[5] = '{digs: 24'h654321, n_dig: 6, done_mode: 0, late: 0, n_exp: 6,
                exp_b: 64'h3534_3332_2E31, exp_ovf: 1, exp_as: 0};
    vecs[6] = '{digs: 24'h000005, n_dig: 1, done_mode: 2, late: 0, n_exp: 3,
                exp_b: 64'h0A0D35, exp_ovf: 0, exp_as: 1};
    vecs[7] = '{digs: 24'h000003, n_dig: 1, done_mode: 1, late: 1, n_exp: 3,
                exp_b: 64'h0A0D33, exp_ovf: 1, exp_as: 1};

    for (int v = 0; v < 8; v++) begin
      nm = $sformatf("vec%0d", v);
      do_reset();
      send(vecs[v].digs, vecs[v].n_dig, vecs[v].done_mode, vecs[v].late);
      wait_idle(nm);
      exp_q.delete();
      for (int i = 0; i < vecs[v].n_exp; i++) exp_q.push_back(vecs[v].exp_b[8*i +: 8]);
      cmp_bytes(nm);
      chk({nm, "_overflow"}, overflow, vecs[v].exp_ovf);
      chk({nm, "_all_sent_pulses"}, as_cnt, vecs[v].exp_as);
      chk({nm, "_frame_err"}, frame_err, 0);
      chk({nm, "_busy_at_all_sent"}, busy_err, 0);
    end

    // Latency and exact frame shape of a single character '7'
    do_reset();
    digit       = 4'd7;
    digit_valid = 1'b1;
    @(negedge clk);
    chk("lat_tx_n", tx, 1);
    tick();
    digit_valid = 1'b0;
    @(negedge clk);
    chk("lat_tx_n1", tx, 1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk($sformatf("lat_frame_c%0d", i), tx, frame_bit(8'h37, i));
    end
    @(negedge clk);
    chk("lat_after_tx", tx, 1);
    chk("lat_after_busy", busy, 0);

    // Several runs back to back: run state restarts after each terminator
    do_reset();
    send(24'h0, 0, 1, 0);
    wait_idle("multi_r0");
    send(24'h5, 1, 1, 0);
    wait_idle("multi_r1");
    send(24'h18, 2, 1, 0);
    wait_idle("multi_r2");
    exp_q.delete();
    exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    exp_q.push_back(8'h35); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    exp_q.push_back(8'h38); exp_q.push_back(8'h2E); exp_q.push_back(8'h31);
    exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    cmp_bytes("multi");
    chk("multi_all_sent_pulses", as_cnt, 3);
    chk("multi_overflow", overflow, 0);
    chk("multi_frame_err", frame_err, 0);

    // Reset during data bit 3 of '7' with further digits buffered
    do_reset();
    digit       = 4'd7;
    digit_valid = 1'b1;
    tick();
    digit = 4'd1;
    tick();
    digit = 4'd2;
    tick();
    digit_valid = 1'b0;
    repeat (16) tick();
    #2;
    chk("mid_rst_pre_tx", tx, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    low_cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) low_cnt++;
    end
    chk("mid_rst_no_resume", low_cnt, 0);
    chk("mid_rst_busy_after", busy, 0);
    rx_q.delete();
    frame_err = 0;
    as_cnt    = 0;
    @(posedge clk);
    #1;
    send(24'h4, 1, 1, 0);
    wait_idle("post_rst");
    exp_q.delete();
    exp_q.push_back(8'h34); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    cmp_bytes("post_rst");
    chk("post_rst_all_sent_pulses", as_cnt, 1);
    chk("post_rst_frame_err", frame_err, 0);
    chk("post_rst_overflow", overflow, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
